// File: rtl/washer_timer.sv
// Washing-machine phase timer: one-second prescaler, seconds countdown and
// done/busy/error flags. Define WASHER_TIMER_FAST_SIM_EN to drop the prescaler.
module washer_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int T_MED    = 600,
  parameter int T_HIGH   = 900,
  parameter int T_SPIN   = 300
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_timer_sel,
  input  logic        i_timer_en,
  input  logic        i_pause,
  output logic        o_timer_done,
  output logic        o_timer_busy,
  output logic        o_timer_err,
  output logic [15:0] o_remain
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRE, HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_sel, w_sel_nxt;
  logic [15:0] r_remain, w_remain_nxt;
  logic        r_err, w_err_nxt;
  logic        r_done, r_busy;
  logic        w_tick;
  logic        w_load;

  function automatic logic [15:0] sel_duration(input logic [1:0] sel);
    case (sel)
      2'b01:   sel_duration = 16'(T_MED);
      2'b10:   sel_duration = 16'(T_HIGH);
      default: sel_duration = 16'(T_SPIN);
    endcase
  endfunction

`ifdef WASHER_TIMER_FAST_SIM_EN
  assign w_tick = ~i_pause;
`else
  localparam logic [25:0] LP_WRAP = 26'(TICK_DIV - 1);
  logic [25:0] r_presc;

  // Prescaler restarts on every (re)load so a new duration always gets full seconds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (w_load || (w_state_nxt != COUNT)) begin
      r_presc <= '0;
    end else if (!i_pause) begin
      r_presc <= (r_presc == LP_WRAP) ? 26'd0 : r_presc + 26'd1;
    end
  end

  assign w_tick = ~i_pause && (r_presc == LP_WRAP);
`endif

  // Abort beats a select change, which beats the tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_remain_nxt = r_remain;
    w_err_nxt    = r_err;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        w_err_nxt    = 1'b0;
        w_remain_nxt = 16'd0;
        if (i_timer_en) begin
          if (i_timer_sel == 2'b00) begin
            w_state_nxt = HOLD;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt  = COUNT;
            w_sel_nxt    = i_timer_sel;
            w_remain_nxt = sel_duration(i_timer_sel);
            w_load       = 1'b1;
          end
        end
      end
      COUNT: begin
        if (!i_timer_en) begin
          w_state_nxt  = IDLE;
          w_remain_nxt = 16'd0;
          w_err_nxt    = 1'b0;
        end else if (i_timer_sel != r_sel) begin
          if (i_timer_sel == 2'b00) begin
            w_state_nxt  = HOLD;
            w_remain_nxt = 16'd0;
            w_err_nxt    = 1'b1;
          end else begin
            w_sel_nxt    = i_timer_sel;
            w_remain_nxt = sel_duration(i_timer_sel);
            w_load       = 1'b1;
          end
        end else if (w_tick) begin
          if (r_remain <= 16'd1) begin
            w_state_nxt  = EXPIRE;
            w_remain_nxt = 16'd0;
          end else begin
            w_remain_nxt = r_remain - 16'd1;
          end
        end
      end
      EXPIRE: begin
        w_state_nxt  = HOLD;
        w_remain_nxt = 16'd0;
      end
      HOLD: begin
        w_remain_nxt = 16'd0;
        if (!i_timer_en) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_remain_nxt = 16'd0;
        w_err_nxt    = 1'b0;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_sel    <= 2'b00;
      r_remain <= 16'd0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_remain <= w_remain_nxt;
      r_err    <= w_err_nxt;
      r_done   <= (w_state_nxt == EXPIRE);
      r_busy   <= (w_state_nxt == COUNT);
    end
  end

  assign o_timer_done = r_done;
  assign o_timer_busy = r_busy;
  assign o_timer_err  = r_err;
  assign o_remain     = r_remain;

endmodule
